// File: rtl/ram_slot_scheduler.sv
// ram_slot_scheduler: 8-phase time-division arbiter for the shared screen/program RAM.
// Each 2 MHz CPU cycle is split into 8 clk16MHz phases. P0 = video fetch, P4 = CPU access
// (phi2 high in P4..P7), P2/P6 = auxiliary DMA slots, odd phases idle. The slots are fixed,
// so no requester can ever contend with another.
// Build option: define RAM_AUX_PORT_EN to implement the auxiliary req/ack port; without it
// the AUX_* inputs are ignored and the P2/P6 slots stay idle.
module ram_slot_scheduler (
    input  logic        clk16MHz,
    input  logic        RESET,
    output logic        clk2MHz,
    input  logic [14:0] VID_adr,
    output logic [7:0]  VID_data,
    output logic        VID_valid,
    input  logic [14:0] CPU_adr,
    input  logic        CPU_sel,
    input  logic        RnW,
    input  logic [7:0]  CPU_wdata,
    output logic [7:0]  CPU_rdata,
    input  logic        AUX_req,
    input  logic        AUX_we,
    input  logic [14:0] AUX_adr,
    input  logic [7:0]  AUX_wdata,
    output logic [7:0]  AUX_rdata,
    output logic        AUX_ack,
    output logic [14:0] RAM_adr,
    output logic        RAM_we,
    output logic [7:0]  RAM_wdata,
    input  logic [7:0]  RAM_rdata
);

    logic [2:0]  r_phase;
    logic [14:0] r_ram_adr;
    logic        r_ram_we;
    logic [7:0]  r_ram_wdata;
    logic        r_vid_rd;      // high during P0 when a video read is on the RAM bus
    logic        r_vid_cap;     // high during P1 while the video byte is on RAM_rdata
    logic [7:0]  r_vid_data;
    logic        r_vid_valid;
    logic        r_cpu_rd;      // high during P4 when a CPU read is on the RAM bus
    logic        r_cpu_cap;     // high during P5 while the CPU byte is on RAM_rdata
    logic [7:0]  r_cpu_rdata;
    logic        w_aux_issue;   // aux access is loaded onto the RAM bus on this edge

    // Decisions are made one phase early: RAM controls are loaded on the edge entering a slot.
    wire w_enter_vid = (r_phase == 3'd7);
    wire w_enter_cpu = (r_phase == 3'd3);
    wire w_enter_aux = (r_phase == 3'd1) || (r_phase == 3'd5);

    // Free-running phase counter; phi2 is simply its MSB.
    always_ff @(posedge clk16MHz) begin
        if (RESET) r_phase <= 3'd0;
        else       r_phase <= r_phase + 3'd1;
    end

    // RAM control register: load the owner of the upcoming slot, otherwise hold address and deassert write.
    always_ff @(posedge clk16MHz) begin
        if (RESET) begin
            r_ram_adr   <= 15'd0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 8'd0;
        end else begin
            r_ram_we <= 1'b0;
            if (w_enter_vid) begin
                r_ram_adr <= VID_adr;
            end else if (w_enter_cpu && CPU_sel) begin
                r_ram_adr <= CPU_adr;
                r_ram_we  <= ~RnW;
                if (!RnW) r_ram_wdata <= CPU_wdata;
            end else if (w_aux_issue) begin
                r_ram_adr <= AUX_adr;
                r_ram_we  <= AUX_we;
                if (AUX_we) r_ram_wdata <= AUX_wdata;
            end
        end
    end

    // Video and CPU read pipelines: track the slot for two cycles and grab RAM_rdata at the end of the second.
    always_ff @(posedge clk16MHz) begin
        if (RESET) begin
            r_vid_rd    <= 1'b0;
            r_vid_cap   <= 1'b0;
            r_vid_data  <= 8'd0;
            r_vid_valid <= 1'b0;
            r_cpu_rd    <= 1'b0;
            r_cpu_cap   <= 1'b0;
            r_cpu_rdata <= 8'd0;
        end else begin
            r_vid_rd    <= w_enter_vid;
            r_vid_cap   <= r_vid_rd;
            r_vid_valid <= r_vid_cap;
            if (r_vid_cap) r_vid_data <= RAM_rdata;
            r_cpu_rd  <= w_enter_cpu && CPU_sel && RnW;
            r_cpu_cap <= r_cpu_rd;
            if (r_cpu_cap) r_cpu_rdata <= RAM_rdata;
        end
    end

`ifdef RAM_AUX_PORT_EN
    typedef enum logic [1:0] {AUX_IDLE, AUX_ISSUE, AUX_CAPTURE, AUX_ACK} aux_state_t;

    aux_state_t r_aux_state;
    aux_state_t w_aux_state_next;
    logic       r_aux_we;
    logic [7:0] r_aux_rdata;
    logic       w_aux_capture;
    logic       w_aux_ack;

    // Aux FSM state register; a reset drops any access in flight without acknowledging it.
    always_ff @(posedge clk16MHz) begin
        if (RESET) r_aux_state <= AUX_IDLE;
        else       r_aux_state <= w_aux_state_next;
    end

    // Aux FSM next state and strobes: one access per slot, ack two cycles after issue.
    always_comb begin
        w_aux_state_next = r_aux_state;
        w_aux_issue      = 1'b0;
        w_aux_capture    = 1'b0;
        w_aux_ack        = 1'b0;
        case (r_aux_state)
            AUX_IDLE: begin
                if (w_enter_aux && AUX_req) begin
                    w_aux_issue      = 1'b1;
                    w_aux_state_next = AUX_ISSUE;
                end
            end
            AUX_ISSUE:   w_aux_state_next = AUX_CAPTURE;
            AUX_CAPTURE: begin
                w_aux_capture    = 1'b1;
                w_aux_state_next = AUX_ACK;
            end
            AUX_ACK: begin
                w_aux_ack        = 1'b1;
                w_aux_state_next = AUX_IDLE;
            end
            default:     w_aux_state_next = AUX_IDLE;
        endcase
    end

    // Remember read/write direction of the access in flight and capture read data.
    always_ff @(posedge clk16MHz) begin
        if (RESET) begin
            r_aux_we    <= 1'b0;
            r_aux_rdata <= 8'd0;
        end else begin
            if (w_aux_issue) r_aux_we <= AUX_we;
            if (w_aux_capture && !r_aux_we) r_aux_rdata <= RAM_rdata;
        end
    end

    assign AUX_ack   = w_aux_ack;
    assign AUX_rdata = r_aux_rdata;
`else
    assign w_aux_issue = 1'b0;
    assign AUX_ack     = 1'b0;
    assign AUX_rdata   = 8'd0;
    wire   w_aux_unused = ^{AUX_req, AUX_we, AUX_adr, AUX_wdata, w_enter_aux};
`endif

    assign clk2MHz   = r_phase[2];
    assign RAM_adr   = r_ram_adr;
    assign RAM_we    = r_ram_we;
    assign RAM_wdata = r_ram_wdata;
    assign VID_data  = r_vid_data;
    assign VID_valid = r_vid_valid;
    assign CPU_rdata = r_cpu_rdata;

endmodule
